// File: rtl/rc4_mem_pkg.sv
// Shared types and defaults for the RC4 S-array memory responder.
// Holds the bus widths, the default read latency and the FSM state type.
package rc4_mem_pkg;

  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_READ_LATENCY = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_RELEASE
  } state_t;

endpackage

// File: rtl/mem_access_responder.sv
// Responder side of the request/request_finished handshake.
// Drives one read or write into the S-array RAM per request.
module mem_access_responder
  import rc4_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              request,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic              request_finished,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int CNT_W = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(READ_LATENCY - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic              r_wren;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_rdata;
  logic              w_accept;
  logic              w_last;

  assign w_accept = (r_state == ST_IDLE) && request;
  // Writes finish one edge into WAIT; reads after the RAM latency.
  assign w_last   = r_we || (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (request) w_state_nxt = ST_ISSUE;
      ST_ISSUE:   w_state_nxt = ST_WAIT;
      ST_WAIT:    if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_RELEASE;
      ST_RELEASE: if (!request) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_wren  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= address;
        r_data <= data;
        r_wren <= we;
        r_we   <= we;
      end
      if (r_state == ST_ISSUE) begin
        r_wren <= 1'b0;
        r_cnt  <= '0;
      end
      if (r_state == ST_WAIT && !r_we) begin
        if (w_last) r_rdata <= mem_q;
        else        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign request_finished = (r_state == ST_DONE);
  assign busy             = (r_state != ST_IDLE);
  assign mem_address      = r_addr;
  assign mem_data         = r_data;
  assign mem_wren         = r_wren;
  assign rdata            = r_rdata;

endmodule

// File: doc/mem_access_responder.md
Name: mem_access_responder

Overview:
- Responder end of the request/request_finished handshake used by the RC4 loop FSMs to touch the S-array memory.
- Accepts one read or write from an initiator, drives the single-port on-chip RAM (registered address, configurable read latency) and returns a one-cycle completion pulse, plus read data for reads.
- Sits between the loop FSMs (or their mux) and the s_memory instance.

Parameters:
- ADDR_W, 8, address width (256-entry S array)
- DATA_W, 8, data width
- READ_LATENCY, 2, clock edges from the RAM sampling the address to valid mem_q (legal 1..4)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- request  in  1  level; initiator holds it high until it samples request_finished
- we  in  1  1 = write, 0 = read; tie to 1 for write-only initiators (init loop)
- address  in  ADDR_W  target address, stable while request high
- data  in  DATA_W  write data, stable while request high
- request_finished  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read result; valid with request_finished on reads, held until next read completes
- busy  out  1  high from acceptance until the responder has seen request low after completion
- mem_address  out  ADDR_W  RAM address, registered
- mem_data  out  DATA_W  RAM write data, registered
- mem_wren  out  1  RAM write enable, registered
- mem_q  in  DATA_W  RAM read data

Behaviour:
- Reset (async, rst_n=0): state IDLE; request_finished, busy, mem_wren = 0; mem_address, mem_data, rdata = 0; latency counter = 0. Takes effect immediately, not at a clock edge.
- States: IDLE, ISSUE, WAIT, DONE, RELEASE.
- IDLE: on edge E0 with request=1, register address, data and we into mem_address, mem_data and mem_wren (= we). busy <= 1. Go to ISSUE.
- ISSUE (one cycle): RAM samples the registered signals at E1. At E1, mem_wren <= 0, so mem_wren is high for exactly one cycle per write. Go to WAIT.
- WAIT:
  - Write: leaves at E2 and sets request_finished, so the pulse is visible in the cycle after E2 (2 cycles after acceptance).
  - Read: counts READ_LATENCY; at edge E(1+READ_LATENCY) captures mem_q into rdata and sets request_finished. With the default, the pulse is visible after E3 (3 cycles).
- DONE (one cycle): request_finished high; next edge clears it. Go to RELEASE.
- RELEASE: stay while request=1. The first edge that samples request=0 goes to IDLE and clears busy. This prevents a held request being accepted twice.
- A new request is therefore accepted no earlier than the edge after the one that saw request low.
- mem_address and mem_data hold their last values outside ISSUE. rdata changes only on read completion.
- Request dropped before completion (protocol violation): the transaction still completes and request_finished still pulses. RELEASE then exits on the next edge.
- Reset mid-transaction: the transaction is dropped with no request_finished pulse. mem_wren is forced to 0 asynchronously.
- request already high when rst_n deasserts: accepted at the first rising edge after deassertion.
- No address arithmetic; widths pass straight through. The latency counter is $clog2(READ_LATENCY+1) bits and never wraps.

Decomposition:
- Package rc4_mem_pkg holds:
  - ADDR_W/DATA_W defaults
  - state enum type (IDLE, ISSUE, WAIT, DONE, RELEASE)
  - READ_LATENCY default
- No sub-module. The latency counter is a few lines inside the single FSM module.

Test Plan:
- Write: after reset, request=1, we=1, address=0x05, data=0x05 -> mem_wren high exactly one cycle with mem_address=0x05 and mem_data=0x05; request_finished one-cycle pulse 2 cycles after acceptance; busy clears one edge after request drops.
- Read: RAM model with latency 2 preloaded with 0xA7 at 0x10; request, we=0, address=0x10 -> mem_wren stays 0; request_finished 3 cycles after acceptance; rdata=0xA7 and held afterwards.
- Init-loop sweep: initiator writes i to address i for i=0..255, dropping request one cycle after each pulse -> 256 pulses, RAM contents equal the index, no double acceptance.
- Held request: request kept high 5 cycles past the pulse -> exactly one transaction and one pulse; next transaction accepted only after request is low.
- Reset mid-read: rst_n=0 during WAIT -> request_finished never pulses, all outputs 0 immediately. After release with request high, the transaction restarts and completes.
- Latency sweep: READ_LATENCY = 1 and 4 -> read pulse at 2 and 5 cycles after acceptance respectively, with correct rdata.
